flux_rate_scheduler: RTL and testbench

//  Time-shares one flux_analyzer/data_rate_detector between NUM_DRIVES drive read channels.

---
 rtl/flux_rate_scheduler_pkg.sv | 33 +++
 rtl/flux_rate_scheduler_rr_arbiter.sv | 57 +++++
 rtl/flux_rate_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_flux_rate_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flux_rate_scheduler_pkg.sv
// Shared types and helpers for the flux rate scheduler: FSM encoding, rate codes,
// and modular index arithmetic used by the round-robin arbiter.
package flux_rate_scheduler_pkg;

  localparam int MAX_DRIVES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_RETRY   = 3'd3,
    ST_DONE    = 3'd4
  } sched_state_e;

  localparam logic [1:0] RATE_500K = 2'b00;
  localparam logic [1:0] RATE_300K = 2'b01;
  localparam logic [1:0] RATE_250K = 2'b10;
  localparam logic [1:0] RATE_1M   = 2'b11;

  // (a + b) mod n for a, b < n <= MAX_DRIVES
  function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b,
                                          input logic [2:0] n);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= n) begin
      s = s - n;
    end else begin
      s = s;
    end
    return s[1:0];
  endfunction

endpackage

// File: rtl/flux_rate_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requester at/after a rotating pointer;
// the pointer moves past the served index when upd_en is strobed.
module flux_rate_scheduler_rr_arbiter
  import flux_rate_scheduler_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         upd_en,
  input  logic [1:0]   upd_idx,
  output logic [N-1:0] gnt_oh,
  output logic [1:0]   gnt_idx,
  output logic         gnt_valid
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] cand;

  // Pointer register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Grant search, scanning offsets high to low so the smallest offset wins
  always_comb begin
    cand      = 2'd0;
    gnt_idx   = 2'd0;
    gnt_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = wrap_add(ptr_q, 2'(i), 3'(N));
      if (req[cand]) begin
        gnt_idx   = cand;
        gnt_valid = 1'b1;
      end else begin
        gnt_idx   = gnt_idx;
      end
    end
    if (gnt_valid) begin
      gnt_oh = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt_oh = '0;
    end
    if (upd_en) begin
      ptr_d = wrap_add(upd_idx, 2'd1, 3'(N));
    end else begin
      ptr_d = ptr_q;
    end
  end

endmodule

// File: rtl/flux_rate_scheduler.sv
// Time-shares one flux analyzer across NUM_DRIVES read channels: arbitrates requests,
// sequences settle/measure/retry, and keeps a per-drive table of locked rates.
module flux_rate_scheduler
  import flux_rate_scheduler_pkg::*;
#(
  parameter int NUM_DRIVES     = 4,
  parameter int SETTLE_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int MAX_RETRY      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DRIVES-1:0]   det_req,
  input  logic                    det_abort,
  input  logic [NUM_DRIVES-1:0]   flux_in,
  output logic                    ana_enable,
  output logic                    ana_flux,
  input  logic [1:0]              ana_rate,
  input  logic                    ana_rate_valid,
  input  logic                    ana_rate_locked,
  output logic                    busy,
  output logic [1:0]              cur_drive,
  output logic                    det_done,
  output logic [1:0]              det_drive,
  output logic                    det_ok,
  output logic [2*NUM_DRIVES-1:0] rate_table,
  output logic [NUM_DRIVES-1:0]   rate_known
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = (SET_W > TMO_W) ? SET_W : TMO_W;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  sched_state_e            state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RTY_W-1:0]        retry_q, retry_d;
  logic [1:0]              cur_drive_q, cur_drive_d;
  logic [NUM_DRIVES-1:0]   cur_oh_q, cur_oh_d;
  logic                    busy_q, busy_d;
  logic                    ana_enable_q, ana_enable_d;
  logic                    det_done_q, det_done_d;
  logic [1:0]              det_drive_q, det_drive_d;
  logic                    det_ok_q, det_ok_d;
  logic                    aborted_q, aborted_d;
  logic [1:0]              res_rate_q, res_rate_d;
  logic [2*NUM_DRIVES-1:0] rate_table_q, rate_table_d;
  logic [NUM_DRIVES-1:0]   rate_known_q, rate_known_d;
  logic [1:0]              rate_in_q, rate_in_d;
  logic                    locked_in_q, locked_in_d;
  logic                    valid_in_q, valid_in_d;

  logic [NUM_DRIVES-1:0]   gnt_oh;
  logic [1:0]              gnt_idx;
  logic                    gnt_valid;
  logic                    arb_upd;
  logic                    end_job, end_ok, end_abort;
  logic                    job_active;

  flux_rate_scheduler_rr_arbiter #(.N(NUM_DRIVES)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (det_req),
    .upd_en    (arb_upd),
    .upd_idx   (cur_drive_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // State, counters, result table and analyzer input stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      retry_q      <= '0;
      cur_drive_q  <= 2'd0;
      cur_oh_q     <= {{(NUM_DRIVES-1){1'b0}}, 1'b1};
      busy_q       <= 1'b0;
      ana_enable_q <= 1'b0;
      det_done_q   <= 1'b0;
      det_drive_q  <= 2'd0;
      det_ok_q     <= 1'b0;
      aborted_q    <= 1'b0;
      res_rate_q   <= 2'd0;
      rate_table_q <= '0;
      rate_known_q <= '0;
      rate_in_q    <= 2'd0;
      locked_in_q  <= 1'b0;
      valid_in_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      cur_drive_q  <= cur_drive_d;
      cur_oh_q     <= cur_oh_d;
      busy_q       <= busy_d;
      ana_enable_q <= ana_enable_d;
      det_done_q   <= det_done_d;
      det_drive_q  <= det_drive_d;
      det_ok_q     <= det_ok_d;
      aborted_q    <= aborted_d;
      res_rate_q   <= res_rate_d;
      rate_table_q <= rate_table_d;
      rate_known_q <= rate_known_d;
      rate_in_q    <= rate_in_d;
      locked_in_q  <= locked_in_d;
      valid_in_q   <= valid_in_d;
    end
  end

  // Next-state and job sequencing
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    cur_drive_d  = cur_drive_q;
    cur_oh_d     = cur_oh_q;
    busy_d       = busy_q;
    det_done_d   = 1'b0;
    det_drive_d  = det_drive_q;
    det_ok_d     = det_ok_q;
    aborted_d    = aborted_q;
    res_rate_d   = res_rate_q;
    rate_table_d = rate_table_q;
    rate_known_d = rate_known_q;
    rate_in_d    = ana_rate;
    locked_in_d  = ana_rate_locked;
    valid_in_d   = ana_rate_valid;
    arb_upd      = 1'b0;
    end_job      = 1'b0;
    end_ok       = 1'b0;
    end_abort    = 1'b0;
    job_active   = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) || (state_q == ST_RETRY);

    if (det_abort && job_active) begin
      end_job   = 1'b1;
      end_abort = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            state_d     = ST_SETTLE;
            cur_drive_d = gnt_idx;
            cur_oh_d    = gnt_oh;
            busy_d      = 1'b1;
            retry_d     = '0;
            cnt_d       = '0;
          end else begin
            busy_d      = 1'b0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_d = ST_MEASURE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          // A lock reported on the final timeout cycle still counts as success
          if (locked_in_q && valid_in_q) begin
            end_job    = 1'b1;
            end_ok     = 1'b1;
            res_rate_d = rate_in_q;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
              state_d = ST_RETRY;
            end else begin
              end_job = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RETRY: begin
          state_d = ST_SETTLE;
          retry_d = retry_q + RTY_W'(1);
          cnt_d   = '0;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          arb_upd = 1'b1;
          if (det_ok_q) begin
            rate_table_d[{cur_drive_q, 1'b0} +: 2] = res_rate_q;
            rate_known_d[cur_drive_q]              = 1'b1;
          end else if (!aborted_q) begin
            rate_known_d[cur_drive_q] = 1'b0;
          end else begin
            rate_known_d = rate_known_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end

    if (end_job) begin
      state_d     = ST_DONE;
      det_done_d  = 1'b1;
      det_drive_d = cur_drive_q;
      det_ok_d    = end_ok;
      aborted_d   = end_abort;
    end else begin
      aborted_d   = aborted_q;
    end

    ana_enable_d = (state_d == ST_MEASURE);
  end

  assign ana_flux   = |(flux_in & cur_oh_q);
  assign ana_enable = ana_enable_q;
  assign busy       = busy_q;
  assign cur_drive  = cur_drive_q;
  assign det_done   = det_done_q;
  assign det_drive  = det_drive_q;
  assign det_ok     = det_ok_q;
  assign rate_table = rate_table_q;
  assign rate_known = rate_known_q;

endmodule

// File: tb/tb_flux_rate_scheduler.sv
// Bench for flux_rate_scheduler: per-drive flux generators and a behavioural analyzer,
// checked against a job-level model of arbitration, retries and the rate table.
module tb_flux_rate_scheduler;
  import flux_rate_scheduler_pkg::*;

  localparam int N      = 4;
  localparam int S      = 16;
  localparam int T      = 200;
  localparam int R      = 2;
  localparam int BUDGET = 3000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] det_req = '0;
  logic         det_abort = 1'b0;
  logic [N-1:0] flux_in = '0;
  logic         ana_enable, ana_flux;
  logic [1:0]   ana_rate = 2'b00;
  logic         ana_rate_valid = 1'b0;
  logic         ana_rate_locked = 1'b0;
  logic         busy, det_done, det_ok;
  logic [1:0]   cur_drive, det_drive;
  logic [2*N-1:0] rate_table;
  logic [N-1:0] rate_known;

  int errors = 0;
  int checks = 0;

  logic [1:0] rate_sel [N];
  bit         silent   [N];
  int         ph       [N];
  int         ptr_m;
  logic [1:0] tab_m    [N];
  bit         known_m  [N];

  logic a_prev = 1'b0, a_have = 1'b0;
  int   a_since = 0, a_last = 0, a_match = 0;

  flux_rate_scheduler #(
    .NUM_DRIVES(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .MAX_RETRY(R)
  ) dut (
    .clk(clk), .reset_n(reset_n), .det_req(det_req), .det_abort(det_abort),
    .flux_in(flux_in), .ana_enable(ana_enable), .ana_flux(ana_flux),
    .ana_rate(ana_rate), .ana_rate_valid(ana_rate_valid), .ana_rate_locked(ana_rate_locked),
    .busy(busy), .cur_drive(cur_drive), .det_done(det_done), .det_drive(det_drive),
    .det_ok(det_ok), .rate_table(rate_table), .rate_known(rate_known)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input logic [1:0] code);
    case (code)
      RATE_1M:   return 2;
      RATE_500K: return 4;
      RATE_300K: return 6;
      default:   return 8;
    endcase
  endfunction

  function automatic logic [1:0] code_of(input int per);
    case (per)
      2:       return RATE_1M;
      4:       return RATE_500K;
      6:       return RATE_300K;
      default: return RATE_250K;
    endcase
  endfunction

  function automatic int drive_period(input int d);
    return silent[d] ? 0 : period_of(rate_sel[d]);
  endfunction

  // One-cycle flux pulse per drive at the period of its assigned rate
  always @(posedge clk) begin
    for (int d = 0; d < N; d++) begin
      if (drive_period(d) == 0) begin
        flux_in[d] <= 1'b0;
        ph[d]      <= 0;
      end else begin
        flux_in[d] <= (ph[d] == 0);
        ph[d]      <= (ph[d] + 1 >= drive_period(d)) ? 0 : ph[d] + 1;
      end
    end
  end

  // Analyzer: locks after the edge-to-edge period repeats three times while enabled
  always @(posedge clk) begin
    if (!ana_enable) begin
      a_prev <= 1'b0; a_have <= 1'b0; a_since <= 0; a_last <= 0; a_match <= 0;
      ana_rate_locked <= 1'b0; ana_rate_valid <= 1'b0; ana_rate <= 2'b00;
    end else begin
      a_prev <= ana_flux;
      if (ana_flux && !a_prev) begin
        if (a_have) begin
          a_match <= (a_since == a_last) ? a_match + 1 : 0;
          a_last  <= a_since;
        end
        a_have  <= 1'b1;
        a_since <= 1;
      end else begin
        a_since <= a_since + 1;
      end
      if (a_match >= 3) begin
        ana_rate_locked <= 1'b1;
        ana_rate_valid  <= 1'b1;
        ana_rate        <= code_of(a_last);
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) begin
      if (m[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [2*N-1:0] exp_table();
    logic [2*N-1:0] v;
    for (int d = 0; d < N; d++) v[2*d +: 2] = tab_m[d];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_known();
    logic [N-1:0] v;
    for (int d = 0; d < N; d++) v[d] = known_m[d];
    return v;
  endfunction

  function automatic void model_reset();
    ptr_m = 0;
    for (int d = 0; d < N; d++) begin
      tab_m[d]   = 2'b00;
      known_m[d] = 1'b0;
    end
  endfunction

  // Serve the job the model expects next; abort_at<0 means no abort
  task automatic run_job(input int abort_at, input bit drop_req);
    int  exp_d, c, busy_c, rises, last_fall, hi_len;
    bit  exp_ok, done_seen, prev_en, timed;
    exp_d  = pick(det_req, ptr_m);
    if (exp_d < 0) begin
      check_val("job_without_request", 0, 1);
      return;
    end
    timed  = silent[exp_d] && (abort_at < 0);
    exp_ok = !silent[exp_d] && (abort_at < 0);
    c = 0; busy_c = -1; rises = 0; last_fall = 0; hi_len = 0;
    done_seen = 1'b0; prev_en = 1'b0;
    while (!done_seen && c < BUDGET) begin
      step();
      c++;
      det_abort = 1'b0;
      if (busy && busy_c < 0) busy_c = c;
      if (ana_enable && !prev_en) begin
        rises++;
        if (rises == 1) check_val("settle_gap", c - busy_c, S);
        else            check_val("retry_gap", c - last_fall, S + 1);
        hi_len = 0;
      end
      if (ana_enable) hi_len++;
      if (!ana_enable && prev_en) begin
        last_fall = c;
        if (timed) check_val("window_len", hi_len, T);
      end
      if (ana_enable && rises == 1 && hi_len - 1 == abort_at) det_abort = 1'b1;
      if (ana_enable && rises == 1 && hi_len == 1 && drop_req) det_req[exp_d] = 1'b0;
      prev_en = ana_enable;
      if (det_done) done_seen = 1'b1;
    end
    det_abort = 1'b0;
    if (!done_seen) begin
      check_val("done_timeout", 0, 1);
      return;
    end
    check_val("det_drive", det_drive, exp_d);
    check_val("det_ok", det_ok, exp_ok);
    check_val("cur_drive", cur_drive, exp_d);
    check_val("ana_flux_mux", ana_flux, flux_in[exp_d]);
    check_val("measure_windows", rises, timed ? R + 1 : 1);
    if (exp_ok) begin
      tab_m[exp_d]   = rate_sel[exp_d];
      known_m[exp_d] = 1'b1;
    end else if (abort_at < 0) begin
      known_m[exp_d] = 1'b0;
    end
    det_req[exp_d] = 1'b0;
    ptr_m = (exp_d + 1) % N;
    step();
    check_val("busy_after_done", busy, 0);
    check_val("done_pulse_width", det_done, 0);
    check_val("rate_table", rate_table, exp_table());
    check_val("rate_known", rate_known, exp_known());
  endtask

  initial begin
    int act, waited;
    for (int d = 0; d < N; d++) begin
      rate_sel[d] = RATE_500K;
      silent[d]   = 1'b0;
    end
    model_reset();

    reset_n = 1'b0;
    repeat (3) step();
    check_val("rst_busy", busy, 0);
    check_val("rst_ana_enable", ana_enable, 0);
    check_val("rst_rate_known", rate_known, 0);
    check_val("rst_rate_table", rate_table, 0);
    check_val("rst_det_done", det_done, 0);
    check_val("rst_cur_drive", cur_drive, 0);
    reset_n = 1'b1;
    act = 0;
    repeat (30) begin
      step();
      if (busy || ana_enable || rate_known != '0 || det_done) act++;
    end
    check_val("idle_no_activity", act, 0);

    // Single request on drive 0 at 250K
    rate_sel[0] = RATE_250K;
    det_req = 4'b0001;
    run_job(-1, 1'b0);

    // Two simultaneous requests: drive 1 then drive 3
    rate_sel[1] = RATE_1M;
    rate_sel[3] = RATE_300K;
    det_req = 4'b1010;
    run_job(-1, 1'b0);
    run_job(-1, 1'b0);

    // Silent drive times out after all retries
    silent[2] = 1'b1;
    det_req = 4'b0100;
    run_job(-1, 1'b0);
    silent[2] = 1'b0;

    // Drive 0 learns 300K, then an abort must leave that entry intact
    rate_sel[0] = RATE_300K;
    det_req = 4'b0001;
    run_job(-1, 1'b0);
    silent[0] = 1'b1;
    det_req = 4'b0001;
    run_job(50, 1'b0);
    silent[0] = 1'b0;

    // Reset in the middle of MEASURE
    silent[1] = 1'b1;
    det_req = 4'b0010;
    waited = 0;
    while (!ana_enable && waited < 200) begin
      step();
      waited++;
    end
    check_val("reach_measure", ana_enable, 1);
    repeat (10) step();
    reset_n = 1'b0;
    step();
    check_val("midrst_busy", busy, 0);
    check_val("midrst_ana_enable", ana_enable, 0);
    check_val("midrst_det_done", det_done, 0);
    check_val("midrst_rate_known", rate_known, 0);
    det_req = '0;
    reset_n = 1'b1;
    silent[1] = 1'b0;
    model_reset();
    act = 0;
    repeat (8) begin
      step();
      if (det_done || busy) act++;
    end
    check_val("midrst_quiet", act, 0);

    // Randomized request sets, rates, silences, aborts and dropped requests
    for (int it = 0; it < 20; it++) begin
      for (int d = 0; d < N; d++) begin
        rate_sel[d] = 2'($urandom_range(0, 3));
        silent[d]   = ($urandom_range(0, 7) == 0);
      end
      det_req = 4'($urandom_range(1, 15));
      while (det_req != '0) begin
        run_job(($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : -1,
                ($urandom_range(0, 5) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
